// File: rtl/router_dest_rx.sv
// Router destination receiver: reads header/payload/parity bytes from a channel
// FIFO, streams payload to a sink, and flags parity errors and stalled packets.
module router_dest_rx (
    input  logic       clock,
    input  logic       resetn,
    input  logic       valid_out,
    input  logic [7:0] data_out,
    input  logic       sink_ready,
    output logic       read_enb,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic [1:0] pkt_addr,
    output logic [5:0] pkt_len,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       timeout,
    output logic [7:0] err_cnt,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_WAIT = 2'd1,
        STREAM   = 2'd2
    } state_t;

    // FIFO handshake: read_enb is only ever raised while valid_out=1; the
    // requested byte is presented on data_out during the following cycle.

    state_t      state_q, state_d;
    logic        rd_pend_q, rd_pend_d;
    logic [6:0]  issue_q, issue_d;
    logic [6:0]  ret_q, ret_d;
    logic [7:0]  xor_q, xor_d;
    logic [4:0]  to_q, to_d;
    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic [1:0]  pkt_addr_q, pkt_addr_d;
    logic [5:0]  pkt_len_q, pkt_len_d;
    logic        pkt_done_q, pkt_done_d;
    logic        parity_err_q, parity_err_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        rd;

    always_comb begin
        state_d      = state_q;
        rd           = 1'b0;
        issue_d      = issue_q;
        ret_d        = ret_q;
        xor_d        = xor_q;
        to_d         = to_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        pkt_addr_d   = pkt_addr_q;
        pkt_len_d    = pkt_len_q;
        pkt_done_d   = 1'b0;
        parity_err_d = 1'b0;
        timeout_d    = 1'b0;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (valid_out) begin
                    rd      = 1'b1;
                    state_d = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                pkt_addr_d = data_out[1:0];
                pkt_len_d  = data_out[7:2];
                xor_d      = data_out;
                issue_d    = {1'b0, data_out[7:2]} + 7'd1;
                ret_d      = {1'b0, data_out[7:2]} + 7'd1;
                to_d       = 5'd0;
                state_d    = STREAM;
            end
            STREAM: begin
                rd = valid_out && sink_ready && (issue_q != 7'd0);
                if (rd) begin
                    issue_d = issue_q - 7'd1;
                end
                if (rd_pend_q) begin
                    if (ret_q > 7'd1) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = data_out;
                        xor_d        = xor_q ^ data_out;
                        ret_d        = ret_q - 7'd1;
                    end else begin
                        pkt_done_d   = 1'b1;
                        parity_err_d = (data_out != xor_q);
                        state_d      = IDLE;
                    end
                end
                // Only an empty FIFO counts toward abort; a stalled sink does not.
                if (rd || valid_out) begin
                    to_d = 5'd0;
                end else if (!rd_pend_q && (issue_q != 7'd0)) begin
                    if (to_q == 5'd31) begin
                        timeout_d = 1'b1;
                        to_d      = 5'd0;
                        state_d   = IDLE;
                    end else begin
                        to_d = to_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((parity_err_d || timeout_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign rd_pend_d = rd;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            rd_pend_q    <= 1'b0;
            issue_q      <= 7'd0;
            ret_q        <= 7'd0;
            xor_q        <= 8'd0;
            to_q         <= 5'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
            pkt_addr_q   <= 2'd0;
            pkt_len_q    <= 6'd0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            timeout_q    <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            rd_pend_q    <= rd_pend_d;
            issue_q      <= issue_d;
            ret_q        <= ret_d;
            xor_q        <= xor_d;
            to_q         <= to_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            pkt_addr_q   <= pkt_addr_d;
            pkt_len_q    <= pkt_len_d;
            pkt_done_q   <= pkt_done_d;
            parity_err_q <= parity_err_d;
            timeout_q    <= timeout_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Strobe is combinational, so it is gated to drop the instant reset asserts.
    assign read_enb   = rd && resetn;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign pkt_addr   = pkt_addr_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_done   = pkt_done_q;
    assign parity_err = parity_err_q;
    assign timeout    = timeout_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_router_dest_rx.sv
// Directed bench for router_dest_rx: a FIFO model feeds packets and a negedge
// monitor records the streamed bytes and status pulses for per-test checks.
module tb_router_dest_rx;

    localparam logic [1:0] ST_STREAM = 2'd2;

    logic       clock;
    logic       resetn;
    logic       valid_out;
    logic [7:0] data_out;
    logic       sink_ready;
    logic       read_enb;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic [1:0] pkt_addr;
    logic [5:0] pkt_len;
    logic       pkt_done;
    logic       parity_err;
    logic       timeout;
    logic [7:0] err_cnt;
    logic       busy;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    router_dest_rx dut (
        .clock      (clock),
        .resetn     (resetn),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .sink_ready (sink_ready),
        .read_enb   (read_enb),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .pkt_addr   (pkt_addr),
        .pkt_len    (pkt_len),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .timeout    (timeout),
        .err_cnt    (err_cnt),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // FIFO model: tasks push at tail, the read strobe pops at head
    logic [7:0] fifo_mem [0:1023];
    logic [9:0] head = 10'd0;
    logic [9:0] tail = 10'd0;
    logic       valid_gate = 1'b0;

    assign valid_out = valid_gate && (head != tail);

    initial data_out = 8'd0;
    always @(posedge clock) begin
        if (read_enb) begin
            data_out <= fifo_mem[head];
            head     <= head + 10'd1;
        end
    end

    // monitor
    logic [7:0] got_q[$];
    int run_q[$];
    int done_cnt = 0;
    int perr_cnt = 0;
    int tmo_cnt = 0;
    int cyc = 0;
    int last_rd_cyc = 0;
    int tmo_cyc = 0;
    int rd_run = 0;
    int bad_rd_cnt = 0;
    int stall_rd_cnt = 0;
    logic done_busy = 1'b0;
    logic tmo_busy = 1'b0;

    always @(negedge clock) begin
        if (byte_valid) got_q.push_back(byte_data);
        if (pkt_done) begin
            done_cnt++;
            done_busy = busy;
        end
        if (parity_err) perr_cnt++;
        if (timeout) begin
            tmo_cnt++;
            tmo_cyc  = cyc;
            tmo_busy = busy;
        end
        if (read_enb) begin
            last_rd_cyc = cyc;
            rd_run++;
        end else if (rd_run != 0) begin
            run_q.push_back(rd_run);
            rd_run = 0;
        end
        if (read_enb && !valid_out) bad_rd_cnt++;
        if (read_enb && !sink_ready && state_dbg == ST_STREAM) stall_rd_cnt++;
        cyc++;
    end

    // driver tasks
    task automatic push_byte(input logic [7:0] b);
        fifo_mem[tail] = b;
        tail = tail + 10'd1;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // scoreboard
    logic [7:0] exp_q[$];

    task automatic test_reset;
        resetn     = 1'b0;
        sink_ready = 1'b1;
        valid_gate = 1'b1;
        push_byte(8'h0D);
        #3;
        checks++;
        if ({read_enb, byte_valid, pkt_done, parity_err, timeout, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {read_enb, byte_valid, pkt_done, parity_err, timeout, busy});
        end
        checks++;
        if ({pkt_addr, pkt_len} !== 8'h00) begin
            errors++;
            $display("FAIL reset_hdr: got %h expected 00", {pkt_addr, pkt_len});
        end
        checks++;
        if (err_cnt !== 8'h00 || byte_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got err_cnt %h byte_data %h expected 00 00", err_cnt, byte_data);
        end
        valid_gate = 1'b0;
        tail = head;
        @(posedge clock);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_basic;
        int base = got_q.size();
        int d0 = done_cnt;
        int p0 = perr_cnt;
        bit ok;
        exp_q = {8'h11, 8'h22, 8'h33};
        push_byte(8'h0D); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h0D);
        valid_gate = 1'b1;
        wait_done(d0 + 1, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done: got no pkt_done expected pkt_done within 40 cycles");
        end
        repeat (2) @(negedge clock);
        checks++;
        if (got_q.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d bytes expected %0d", got_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, got_q[base + i], exp_q[i]);
            end
        end
        checks++;
        if (pkt_addr !== 2'd1 || pkt_len !== 6'd3) begin
            errors++;
            $display("FAIL basic_hdr: got addr %0d len %0d expected addr 1 len 3", pkt_addr, pkt_len);
        end
        checks++;
        if (perr_cnt - p0 != 0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL basic_parity: got perr %0d err_cnt %0d expected 0 0", perr_cnt - p0, err_cnt);
        end
        checks++;
        if (done_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_at_done: got %b expected 0", done_busy);
        end
        // header read alone, then payload + parity reads on four consecutive cycles
        checks++;
        if (run_q.size() < 2 || run_q[$] != 4 || run_q[$-1] != 1) begin
            errors++;
            $display("FAIL basic_read_runs: got last run %0d expected 4 after a 1-cycle header read",
                     (run_q.size() > 0) ? run_q[$] : -1);
        end
    endtask

    task automatic test_parity_err;
        int d0 = done_cnt;
        int p0 = perr_cnt;
        bit ok;
        push_byte(8'h0D); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h0E);
        wait_done(d0 + 1, 40, ok);
        repeat (2) @(negedge clock);
        checks++;
        if (!ok || perr_cnt - p0 != 1) begin
            errors++;
            $display("FAIL parity_err_pulse: got done %0b perr %0d expected done 1 perr 1", ok, perr_cnt - p0);
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL parity_err_cnt: got %0d expected 1", err_cnt);
        end
    endtask

    task automatic test_zero_len;
        int base = got_q.size();
        int d0 = done_cnt;
        int p0 = perr_cnt;
        bit ok;
        push_byte(8'h02); push_byte(8'h02);
        wait_done(d0 + 1, 20, ok);
        repeat (2) @(negedge clock);
        checks++;
        if (!ok || got_q.size() != base) begin
            errors++;
            $display("FAIL zero_len_stream: got done %0b bytes %0d expected done 1 bytes 0", ok, got_q.size() - base);
        end
        checks++;
        if (pkt_addr !== 2'd2 || pkt_len !== 6'd0 || perr_cnt != p0) begin
            errors++;
            $display("FAIL zero_len_hdr: got addr %0d len %0d perr %0d expected 2 0 0", pkt_addr, pkt_len, perr_cnt - p0);
        end
    endtask

    task automatic test_stall;
        int base = got_q.size();
        int d0 = done_cnt;
        int t0 = tmo_cnt;
        int s0 = stall_rd_cnt;
        bit ok;
        bit seen = 1'b0;
        exp_q = {8'h11, 8'h22, 8'h33};
        @(posedge clock);
        #1;
        push_byte(8'h0D); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h0D);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (state_dbg == ST_STREAM && read_enb) seen = 1'b1;
        end
        // sink held off longer than the abort window while the FIFO stays non-empty
        @(posedge clock);
        #1 sink_ready = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        checks++;
        if (!seen || busy !== 1'b1 || tmo_cnt != t0) begin
            errors++;
            $display("FAIL stall_hold: got seen %0b busy %b timeouts %0d expected 1 1 0", seen, busy, tmo_cnt - t0);
        end
        sink_ready = 1'b1;
        wait_done(d0 + 1, 20, ok);
        repeat (2) @(negedge clock);
        checks++;
        if (stall_rd_cnt != s0) begin
            errors++;
            $display("FAIL stall_no_read: got %0d reads while sink_ready=0 expected 0", stall_rd_cnt - s0);
        end
        checks++;
        if (!ok || got_q.size() - base != 3) begin
            errors++;
            $display("FAIL stall_done: got done %0b bytes %0d expected 1 3", ok, got_q.size() - base);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h expected %h", i, got_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout;
        int base = got_q.size();
        int d0 = done_cnt;
        int t0 = tmo_cnt;
        bit seen = 1'b0;
        push_byte(8'h0D); push_byte(8'h11);
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clock);
            if (tmo_cnt > t0) seen = 1'b1;
        end
        repeat (3) @(negedge clock);
        checks++;
        if (!seen || tmo_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got seen %0b busy %b expected 1 0", seen, tmo_busy);
        end
        // read of 0x11, its return cycle, then 32 empty cycles, then the registered pulse
        checks++;
        if (tmo_cyc - last_rd_cyc != 34) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected 34", tmo_cyc - last_rd_cyc);
        end
        checks++;
        if (err_cnt !== 8'd2 || done_cnt != d0) begin
            errors++;
            $display("FAIL timeout_cnt: got err_cnt %0d done %0d expected 2 0", err_cnt, done_cnt - d0);
        end
        checks++;
        if (got_q.size() - base != 1 || got_q[$] !== 8'h11) begin
            errors++;
            $display("FAIL timeout_byte: got %0d bytes expected one byte 11", got_q.size() - base);
        end
    endtask

    task automatic test_back_to_back;
        int base = got_q.size();
        int d0 = done_cnt;
        int p0 = perr_cnt;
        bit ok;
        @(posedge clock);
        #1;
        push_byte(8'h03); push_byte(8'h03);
        push_byte(8'h05); push_byte(8'hAA); push_byte(8'hAF);
        wait_done(d0 + 2, 40, ok);
        repeat (2) @(negedge clock);
        checks++;
        if (!ok || perr_cnt != p0 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL b2b_done: got done %0b perr %0d err_cnt %0d expected 1 0 2", ok, perr_cnt - p0, err_cnt);
        end
        checks++;
        if (got_q.size() - base != 1 || got_q[$] !== 8'hAA) begin
            errors++;
            $display("FAIL b2b_byte: got %0d bytes expected one byte aa", got_q.size() - base);
        end
        checks++;
        if (pkt_addr !== 2'd1 || pkt_len !== 6'd1) begin
            errors++;
            $display("FAIL b2b_hdr: got addr %0d len %0d expected 1 1", pkt_addr, pkt_len);
        end
        checks++;
        if (bad_rd_cnt != 0) begin
            errors++;
            $display("FAIL read_without_valid: got %0d expected 0", bad_rd_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int base = got_q.size();
        int d0;
        bit ok;
        bit seen = 1'b0;
        @(posedge clock);
        #1;
        push_byte(8'h0D); push_byte(8'h11); push_byte(8'h22);
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            if (got_q.size() - base >= 2) seen = 1'b1;
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (!seen || {read_enb, byte_valid, pkt_done, parity_err, timeout, busy} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_flags: got seen %0b flags %b expected 1 000000", seen,
                     {read_enb, byte_valid, pkt_done, parity_err, timeout, busy});
        end
        checks++;
        if ({pkt_addr, pkt_len} !== 8'h00 || err_cnt !== 8'h00 || byte_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_regs: got hdr %h err_cnt %h byte_data %h expected 00 00 00",
                     {pkt_addr, pkt_len}, err_cnt, byte_data);
        end
        d0 = done_cnt;
        base = got_q.size();
        tail = head;
        push_byte(8'h06); push_byte(8'h55); push_byte(8'h53);
        @(posedge clock);
        #1;
        checks++;
        if (read_enb !== 1'b0 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL midreset_no_read: got read_enb %b valid_out %b expected 0 1", read_enb, valid_out);
        end
        resetn = 1'b1;
        wait_done(d0 + 1, 30, ok);
        repeat (2) @(negedge clock);
        checks++;
        if (!ok || done_cnt - d0 != 1 || pkt_addr !== 2'd2 || pkt_len !== 6'd1) begin
            errors++;
            $display("FAIL midreset_next_hdr: got done %0d addr %0d len %0d expected 1 2 1",
                     done_cnt - d0, pkt_addr, pkt_len);
        end
        checks++;
        if (got_q.size() - base != 1 || got_q[$] !== 8'h55 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midreset_payload: got %0d bytes err_cnt %0d expected one byte 55, err_cnt 0",
                     got_q.size() - base, err_cnt);
        end
    endtask

    task automatic test_saturate;
        int d0 = done_cnt;
        int p0 = perr_cnt;
        bit idle = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 260; i++) begin
            push_byte(8'h00);
            push_byte(8'h01);
        end
        for (int i = 0; i < 2000 && !idle; i++) begin
            @(negedge clock);
            if (head == tail && !busy) idle = 1'b1;
        end
        repeat (3) @(negedge clock);
        checks++;
        if (!idle || done_cnt - d0 != 260 || perr_cnt - p0 != 260) begin
            errors++;
            $display("FAIL sat_packets: got idle %0b done %0d perr %0d expected 1 260 260",
                     idle, done_cnt - d0, perr_cnt - p0);
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_err_cnt: got %0d expected 255", err_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity_err;
        test_zero_len;
        test_stall;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_saturate;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_dest_rx.md
ROUTER_DEST_RX -- requirements
Module: router_dest_rx

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port valid_out  input  1  channel FIFO not empty.
REQ-004 SHALL have port data_out  input  8  FIFO read data, valid the cycle after an accepted read_enb.
REQ-005 SHALL have port sink_ready  input  1  downstream consumer can accept a byte.
REQ-006 SHALL have port read_enb  output  1  FIFO read strobe.
REQ-007 SHALL have port byte_valid  output  1  one-cycle pulse qualifying byte_data as payload.
REQ-008 SHALL have port byte_data  output  8  payload byte.
REQ-009 SHALL have port pkt_addr  output  2  header[1:0] of current packet.
REQ-010 SHALL have port pkt_len  output  6  header[7:2] of current packet.
REQ-011 SHALL have port pkt_done  output  1  one-cycle pulse, packet completed.
REQ-012 SHALL have port parity_err  output  1  one-cycle pulse with pkt_done on parity mismatch.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse on packet abort.
REQ-014 SHALL have port err_cnt  output  8  saturating count of parity errors plus timeouts.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 Packet format SHALL be: header byte, then pkt_len payload bytes, then one parity byte; pkt_len 0 is legal (header + parity only).
REQ-017 Expected parity SHALL be XOR of header and all payload bytes.
REQ-018 FSM states SHALL be IDLE, HDR_WAIT, STREAM.
REQ-019 IDLE: when valid_out=1, assert read_enb for exactly one cycle and go to HDR_WAIT; sink_ready ignored for the header read.
REQ-020 HDR_WAIT: read_enb=0; next cycle capture data_out into pkt_addr/pkt_len, initialise running XOR to header, issue-remaining = pkt_len+1, return-remaining = pkt_len+1; go to STREAM.
REQ-021 STREAM: read_enb = valid_out & sink_ready & (issue-remaining != 0); each asserted cycle decrements issue-remaining.
REQ-022 A byte SHALL return on data_out the cycle after each read_enb; returns while return-remaining > 1 are payload: byte_valid=1, byte_data=data_out, XOR updated, return-remaining decremented.
REQ-023 The return with return-remaining = 1 is parity: pkt_done=1, parity_err=(data_out != XOR), go to IDLE.
REQ-024 Back-to-back reads SHALL sustain one byte per cycle while valid_out and sink_ready stay high.
REQ-025 No read SHALL be issued for the next header until the FSM has returned to IDLE (minimum one idle cycle between packets).
REQ-026 Timeout: in STREAM with no read outstanding, 32 consecutive cycles of valid_out=0 while issue-remaining != 0 SHALL pulse timeout and return to IDLE without pkt_done; counter clears on any read.
REQ-027 sink_ready low SHALL only stall issue; it SHALL NOT advance the timeout counter when valid_out=1.
REQ-028 err_cnt SHALL increment on each parity_err or timeout pulse and hold at 255.
REQ-029 read_enb SHALL never assert when valid_out=0.

Reset
REQ-030 On resetn=0, immediately: state IDLE, read_enb=0, byte_valid=0, pkt_done=0, parity_err=0, timeout=0, busy=0, byte_data=0, pkt_addr=0, pkt_len=0, err_cnt=0, all counters and XOR cleared.
REQ-031 Reset asserted mid-packet SHALL abandon the packet with no pkt_done; after release the block SHALL treat the next FIFO byte as a header.

Verification
REQ-032 FIFO holds 0D,11,22,33,0D, sink_ready=1 -> reads on consecutive cycles after header, byte_valid with 11,22,33, pkt_addr=1, pkt_len=3, pkt_done=1, parity_err=0.
REQ-033 Same packet with parity 0E -> pkt_done=1, parity_err=1, err_cnt=1.
REQ-034 FIFO holds 02,02 -> no byte_valid, pkt_addr=2, pkt_len=0, pkt_done=1, parity_err=0.
REQ-035 0D,11,22,33,0D with sink_ready=0 for 5 cycles after byte 11 -> read_enb low those cycles, no timeout, correct completion.
REQ-036 Header 0D and byte 11 only, valid_out then 0 for 32 cycles -> timeout=1, busy=0, err_cnt increments, no pkt_done.
REQ-037 resetn pulsed low after byte 22 -> all outputs 0 asynchronously; next FIFO byte 06 is taken as header (pkt_addr=2, pkt_len=1).
